lsu_mem_port: RTL
=================

LSU_MEM_PORT -- requirements
Module: lsu_mem_port

Interface
REQ-001 Parameter BASE_ADDR, default 32'h1001_0000: byte address that maps to data-memory word 0.
REQ-002 Parameter DEPTH_WORDS, default 2048: number of addressable data-memory words; word index width is fixed at 11 bits.
REQ-003 The block SHALL use one clock `clk`; reset `rst_n` SHALL be synchronous and active-low.
REQ-004 clk  input  1  rising-edge clock for all state; memory writes complete at the following falling edge.
REQ-005 rst_n  input  1  synchronous active-low reset.
REQ-006 req_valid  input  1  pipeline MEM stage presents a request.
REQ-007 req_ready  output  1  block accepts a request this cycle.
REQ-008 req_we  input  1  1 = store, 0 = load.
REQ-009 req_size  input  2  00 byte, 01 half, 11 word, 10 reserved.
REQ-010 req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-011 req_addr  input  32  byte address.
REQ-012 req_wdata  input  32  store data, right-justified.
REQ-013 resp_valid  output  1  one-cycle completion pulse.
REQ-014 resp_rdata  output  32  extended load data; 0 for stores and errors.
REQ-015 resp_err  output  1  request rejected: misaligned, reserved size, or out of range.
REQ-016 mem_ena  output  1  data-memory read enable.
REQ-017 mem_wena  output  1  data-memory write enable.
REQ-018 mem_addr  output  11  word index.
REQ-019 mem_wdata  output  32  write data to data memory.
REQ-020 mem_data_bit  output  2  write width to memory: 00 writes [7:0], 01 writes [15:0], 11 writes the full word.
REQ-021 mem_rdata  input  32  combinational read data from memory, valid in the same cycle as mem_ena.

Function
REQ-022 The FSM states SHALL be IDLE, LOAD, STORE, RMW_RD, RMW_WR and RESP; req_ready SHALL be 1 only in IDLE with rst_n=1.
REQ-023 Acceptance SHALL occur at a rising edge with req_valid=1 and req_ready=1; all request fields SHALL be latched on that edge.
REQ-024 Offset and index: off=(req_addr-BASE_ADDR), word index=off[12:2], byte lane=off[1:0]; lanes are little-endian, lane 0 = bits [7:0].
REQ-025 Error conditions: req_size=10; half with lane[0]=1; word with lane!=0; or off>=4*DEPTH_WORDS (unsigned, so addresses below BASE also fail).
REQ-026 Error request: IDLE->RESP; no memory access occurs; resp_err=1.
REQ-027 Load: IDLE->LOAD; in LOAD drive mem_ena=1 and mem_addr; capture mem_rdata at the exiting edge; shift the selected lane to bit 0; extend per req_signed; ->RESP.
REQ-028 Store with lane=0 (any size): IDLE->STORE; drive mem_ena=1, mem_wena=1, mem_data_bit=req_size, mem_wdata=req_wdata; ->RESP.
REQ-029 Sub-word store with lane!=0 SHALL use read-modify-write:
  - RMW_RD: drive mem_ena=1; capture mem_rdata into the merge register; ->RMW_WR.
  - RMW_WR: drive mem_ena=1, mem_wena=1, mem_data_bit=11, mem_wdata=merged word with only the target byte or half replaced; ->RESP.
REQ-030 RESP: resp_valid=1 for exactly one cycle, then ->IDLE; no response backpressure.
REQ-031 Latency from the acceptance edge: error, 1 cycle; load, aligned store and lane-0 sub-word store, 2 cycles; RMW store, 3 cycles.
REQ-032 Back-to-back: a new request SHALL NOT be accepted before the cycle after resp_valid; peak throughput is one request per 3 cycles.
REQ-033 resp_rdata and resp_err SHALL hold their values until the next RESP.
REQ-034 In IDLE and RESP: mem_ena=0, mem_wena=0, mem_addr=0, mem_wdata=0, mem_data_bit=00.
REQ-035 mem_wena SHALL be gated combinationally by rst_n, so no memory write occurs in any cycle with rst_n=0.

Reset
REQ-036 With rst_n=0 at a rising edge: state->IDLE; resp_valid=0, resp_rdata=0, resp_err=0; merge and latch registers cleared.
REQ-037 With rst_n=0 in any cycle: req_ready=0, mem_ena=0, mem_wena=0.
REQ-038 Reset mid-operation SHALL abandon the operation: no response, no partial RMW write; a request presented during reset is not accepted.

Verification
REQ-039 Word store then load: store 32'hDEADBEEF to BASE+0x10, then load the word -> mem_addr=4 both times; resp_rdata=32'hDEADBEEF, 2 cycles after each acceptance.
REQ-040 Byte RMW: word at BASE+0x20 = 32'h11223344; sb 8'hAA to BASE+0x22 -> RMW_RD then RMW_WR with data_bit=11 and wdata=32'h11AA3344; resp 3 cycles after acceptance.
REQ-041 Extension: word = 32'h0000_80F0; lh signed at lane 0 -> 32'hFFFF80F0; lhu -> 32'h000080F0; lb signed at lane 1 -> 32'hFFFFFF80.
REQ-042 Errors: lw at BASE+0x2, lh at BASE+0x1, req_size=10, and address BASE+0x2000 -> resp_err=1 after 1 cycle; mem_ena and mem_wena stay 0.
REQ-043 Reset during RMW_WR: rst_n=0 in that cycle -> mem_wena=0; memory word unchanged; no resp_valid; req_ready=1 in the first cycle after reset is released.
REQ-044 Back-to-back: req_valid held high with 3 loads -> accepted at cycles 0, 3 and 6; exactly one resp_valid per request, in order.

Source files
------------

// File: rtl/lsu_mem_port.sv
// lsu_mem_port: load/store unit port between the pipeline MEM stage and a
// word-organised data memory. Handles byte/half/word loads with sign or zero
// extension, aligned stores directly, and off-lane sub-word stores through a
// read-modify-write of the containing word. Bad requests are answered with an
// error response without touching memory.
module lsu_mem_port #(
    parameter logic [31:0] BASE_ADDR   = 32'h1001_0000,
    parameter int          DEPTH_WORDS = 2048
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_signed,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_err,
    output logic        mem_ena,
    output logic        mem_wena,
    output logic [10:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [1:0]  mem_data_bit,
    input  logic [31:0] mem_rdata
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STORE,
        RMW_RD,
        RMW_WR,
        RESP
    } state_t;

    localparam logic [31:0] RANGE_BYTES = 32'(4 * DEPTH_WORDS);

    state_t      state_q, state_d;

    logic        we_q;
    logic [1:0]  size_q;
    logic        signed_q;
    logic [1:0]  lane_q;
    logic [10:0] index_q;
    logic [31:0] wdata_q;
    logic [31:0] merge_q;
    logic [31:0] respRdata_q;
    logic        respErr_q;

    logic [31:0] reqOff;
    logic [1:0]  reqLane;
    logic        reqErr;
    logic        accept;
    logic [31:0] loadShifted;
    logic [31:0] loadExt;
    logic [31:0] mergedWord;
    logic        wenaRaw;

    // Decode the incoming request: offset from the window base, lane, and whether it must be rejected
    always_comb begin
        reqOff  = req_addr - BASE_ADDR;
        reqLane = reqOff[1:0];
        reqErr  = (req_size == 2'b10)
               || (req_size == 2'b01 && reqLane[0])
               || (req_size == 2'b11 && reqLane != 2'b00)
               || (reqOff >= RANGE_BYTES);
        accept  = req_valid && req_ready;
    end

    // State register; reset drops any operation in flight back to IDLE
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state selection: errors skip memory, off-lane sub-word stores go through RMW
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    if (reqErr) begin
                        state_d = RESP;
                    end else if (!req_we) begin
                        state_d = LOAD;
                    end else if (reqLane == 2'b00) begin
                        state_d = STORE;
                    end else begin
                        state_d = RMW_RD;
                    end
                end
            end
            LOAD:    state_d = RESP;
            STORE:   state_d = RESP;
            RMW_RD:  state_d = RMW_WR;
            RMW_WR:  state_d = RESP;
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Bring the addressed lane down to bit 0 and extend it to a full word
    always_comb begin
        loadShifted = mem_rdata >> {lane_q, 3'b000};
        case (size_q)
            2'b00:   loadExt = signed_q ? {{24{loadShifted[7]}}, loadShifted[7:0]}
                                        : {24'h0, loadShifted[7:0]};
            2'b01:   loadExt = signed_q ? {{16{loadShifted[15]}}, loadShifted[15:0]}
                                        : {16'h0, loadShifted[15:0]};
            default: loadExt = loadShifted;
        endcase
    end

    // Splice the store byte or half into the word read back during RMW_RD
    always_comb begin
        mergedWord = merge_q;
        if (size_q == 2'b01) begin
            mergedWord[31:16] = wdata_q[15:0];
        end else begin
            case (lane_q)
                2'd1:    mergedWord[15:8]  = wdata_q[7:0];
                2'd2:    mergedWord[23:16] = wdata_q[7:0];
                2'd3:    mergedWord[31:24] = wdata_q[7:0];
                default: mergedWord[7:0]   = wdata_q[7:0];
            endcase
        end
    end

    // Request latch, RMW merge buffer and the response registers that hold until the next RESP
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            we_q        <= 1'b0;
            size_q      <= 2'b00;
            signed_q    <= 1'b0;
            lane_q      <= 2'b00;
            index_q     <= 11'h000;
            wdata_q     <= 32'h0;
            merge_q     <= 32'h0;
            respRdata_q <= 32'h0;
            respErr_q   <= 1'b0;
        end else begin
            if (accept) begin
                we_q     <= req_we;
                size_q   <= req_size;
                signed_q <= req_signed;
                lane_q   <= reqLane;
                index_q  <= reqOff[12:2];
                wdata_q  <= req_wdata;
                if (reqErr) begin
                    respRdata_q <= 32'h0;
                    respErr_q   <= 1'b1;
                end
            end
            case (state_q)
                LOAD: begin
                    respRdata_q <= loadExt;
                    respErr_q   <= 1'b0;
                end
                STORE, RMW_WR: begin
                    respRdata_q <= 32'h0;
                    respErr_q   <= 1'b0;
                end
                RMW_RD: begin
                    merge_q <= mem_rdata;
                end
                default: begin
                end
            endcase
        end
    end

    // Drive memory and handshake outputs from the current state; reset masks every strobe immediately
    always_comb begin
        mem_ena      = 1'b0;
        wenaRaw      = 1'b0;
        mem_addr     = 11'h000;
        mem_wdata    = 32'h0;
        mem_data_bit = 2'b00;
        case (state_q)
            LOAD: begin
                mem_ena  = 1'b1;
                mem_addr = index_q;
            end
            STORE: begin
                mem_ena      = 1'b1;
                wenaRaw      = we_q;
                mem_addr     = index_q;
                mem_wdata    = wdata_q;
                mem_data_bit = size_q;
            end
            RMW_RD: begin
                mem_ena  = 1'b1;
                mem_addr = index_q;
            end
            RMW_WR: begin
                mem_ena      = 1'b1;
                wenaRaw      = we_q;
                mem_addr     = index_q;
                mem_wdata    = mergedWord;
                mem_data_bit = 2'b11;
            end
            default: begin
            end
        endcase
        mem_ena    = mem_ena && rst_n;
        mem_wena   = wenaRaw && rst_n;
        req_ready  = rst_n && (state_q == IDLE);
        resp_valid = rst_n && (state_q == RESP);
        resp_rdata = respRdata_q;
        resp_err   = respErr_q;
    end

endmodule
